// File: rtl/mul_arbiter.sv
// Two-requester round-robin front end for a shift-free add/decrement multiplier.
// Sequences a shared datapath (A reg, B down-counter, P accumulator) through one job at a time.
module mul_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic [15:0] a0,
    input  logic [15:0] b0,
    input  logic        req1,
    input  logic [15:0] a1,
    input  logic [15:0] b1,
    output logic        ack0,
    output logic        ack1,
    output logic [15:0] prod,
    output logic        busy,
    output logic [15:0] data_in,
    output logic        ldA,
    output logic        ldB,
    output logic        ldP,
    output logic        clrP,
    output logic        decB,
    input  logic        eqz,
    input  logic [15:0] p_in
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_LDA  = 3'd1;
    localparam logic [2:0] S_LDB  = 3'd2;
    localparam logic [2:0] S_MUL  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    logic [2:0]  state_q, state_d;
    logic        owner_q, owner_d;
    logic        last_q, last_d;
    logic [15:0] prod_q, prod_d;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        prod_d  = prod_q;
        case (state_q)
            S_IDLE: begin
                if (req0 || req1) begin
                    // On a tie the requester that was not served last wins.
                    owner_d = (req0 && req1) ? ~last_q : req1;
                    last_d  = owner_d;
                    state_d = S_LDA;
                end
            end
            S_LDA:  state_d = S_LDB;
            S_LDB:  state_d = S_MUL;
            S_MUL: begin
                if (eqz) begin
                    prod_d  = p_in;
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // last_q resets to 1 so requester 0 takes the first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            prod_q  <= 16'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            prod_q  <= prod_d;
        end
    end

    always_comb begin
        ack0    = 1'b0;
        ack1    = 1'b0;
        ldA     = 1'b0;
        ldB     = 1'b0;
        ldP     = 1'b0;
        clrP    = 1'b0;
        decB    = 1'b0;
        data_in = 16'd0;
        case (state_q)
            S_LDA: begin
                ldA     = 1'b1;
                data_in = owner_q ? a1 : a0;
            end
            S_LDB: begin
                ldB     = 1'b1;
                clrP    = 1'b1;
                data_in = owner_q ? b1 : b0;
            end
            S_MUL: begin
                ldP  = ~eqz;
                decB = ~eqz;
            end
            S_DONE: begin
                ack0 = ~owner_q;
                ack1 = owner_q;
            end
            default: ;
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign prod = prod_q;

endmodule

// File: tb/tb_mul_arbiter.sv
// Randomized bench for mul_arbiter: behavioural datapath plus a job-level reference
// model (round-robin winner, product mod 2^16, ack at edge b+4).
module tb_mul_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1;
    logic [15:0] a0, b0, a1, b1;
    logic        ack0, ack1, busy;
    logic [15:0] prod, data_in;
    logic        ldA, ldB, ldP, clrP, decB;
    logic        eqz;
    logic [15:0] p_in;

    int errors = 0;
    int checks = 0;
    logic last_m;

    logic [15:0] dp_a, dp_b, dp_p;

    always #5 clk = ~clk;

    mul_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .a0(a0), .b0(b0),
        .req1(req1), .a1(a1), .b1(b1),
        .ack0(ack0), .ack1(ack1), .prod(prod), .busy(busy),
        .data_in(data_in), .ldA(ldA), .ldB(ldB), .ldP(ldP),
        .clrP(clrP), .decB(decB), .eqz(eqz), .p_in(p_in)
    );

    // Datapath driven by the controller's Moore outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dp_a <= 16'd0;
            dp_b <= 16'd0;
            dp_p <= 16'd0;
        end else begin
            if (ldA) dp_a <= data_in;
            if (ldB) dp_b <= data_in;
            else if (decB) dp_b <= dp_b - 16'd1;
            if (clrP) dp_p <= 16'd0;
            else if (ldP) dp_p <= dp_p + dp_a;
        end
    end
    assign eqz  = (dp_b == 16'd0);
    assign p_in = dp_p;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {ack0, ack1, busy, ldA, ldB, ldP, clrP, decB}, 0);
        check({tag, "_bus"}, {prod, data_in}, 0);
    endtask

    // Called at a negedge in IDLE with at least one req high; returns at the negedge of the ack cycle.
    task automatic run_one();
        logic        w;
        logic [15:0] ea, eb, ep;
        int          n;
        bit          done;
        w      = (req0 && req1) ? ~last_m : req1;
        last_m = w;
        ea     = w ? a1 : a0;
        eb     = w ? b1 : b0;
        ep     = 16'(32'(ea) * 32'(eb));
        n      = 0;
        done   = 0;
        while (!done && n < 200) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                check("lda_ctl", {ldA, ldB, busy}, 3'b101);
                check("lda_data", data_in, ea);
            end
            if (n == 2) begin
                check("ldb_ctl", {ldA, ldB, clrP}, 3'b011);
                check("ldb_data", data_in, eb);
            end
            if (n == 3) check("mul_ldp", ldP, (eb != 16'd0));
            if (ack0 || ack1) begin
                done = 1;
                check("ack_lat", n, 32'(eb) + 4);
                check("ack_who", {ack1, ack0}, w ? 2'b10 : 2'b01);
                check("prod", prod, ep);
            end
        end
        if (!done) check("ack_timeout", 0, 1);
    endtask

    task automatic post_job();
        @(negedge clk);
        check("idle_after", {busy, ack1, ack0}, 3'b000);
    endtask

    initial begin
        rst = 1'b1;
        req0 = 0; req1 = 0;
        a0 = 0; b0 = 0; a1 = 0; b1 = 0;
        repeat (2) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        last_m = 1'b1;
        @(negedge clk);

        // Tie after reset: 0 first; 0 re-requests so the next tie goes to 1, then 0 again.
        a0 = 16'd2; b0 = 16'd2; a1 = 16'd3; b1 = 16'd1;
        req0 = 1; req1 = 1;
        run_one();
        post_job();
        run_one();
        req1 = 0;
        post_job();
        run_one();
        req0 = 0;
        post_job();

        req0 = 1; a0 = 16'd5; b0 = 16'd3;
        run_one();
        req0 = 0;
        post_job();

        req1 = 1; a1 = 16'd9; b1 = 16'd0;
        run_one();
        req1 = 0;
        post_job();

        req0 = 1; a0 = 16'h8000; b0 = 16'd2;
        run_one();
        req0 = 0;
        post_job();

        // Abandon a job mid-multiply, then let the held request restart it.
        req0 = 1; a0 = 16'd7; b0 = 16'd10;
        repeat (4) @(negedge clk);
        check("abort_busy", {busy, ldP}, 2'b11);
        #2 rst = 1'b1;
        #1 check_all_zero("abort_async");
        @(negedge clk);
        check_all_zero("abort_hold");
        rst = 1'b0;
        last_m = 1'b1;
        run_one();

        for (int it = 0; it < 40; it++) begin
            if (last_m == 1'b0) begin
                req0 = ($urandom_range(0, 2) == 0);
                if (req0) begin a0 = 16'($urandom); b0 = 16'($urandom_range(0, 20)); end
            end else begin
                req1 = ($urandom_range(0, 2) == 0);
                if (req1) begin a1 = 16'($urandom); b1 = 16'($urandom_range(0, 20)); end
            end
            post_job();
            if (!req0 && $urandom_range(0, 1) == 1) begin
                req0 = 1; a0 = 16'($urandom); b0 = 16'($urandom_range(0, 20));
            end
            if (!req1 && $urandom_range(0, 1) == 1) begin
                req1 = 1; a1 = 16'($urandom); b1 = 16'($urandom_range(0, 20));
            end
            if (!req0 && !req1) begin
                req0 = 1; a0 = 16'($urandom); b0 = 16'($urandom_range(0, 20));
            end
            run_one();
        end
        req0 = 0; req1 = 0;
        post_job();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
